// File: rtl/ps2_letter_rx.sv
// PS/2 scan-code-set-2 receiver. Turns key presses into one-cycle strobes:
// a letter code (A=1..Z=26), Enter, and frame errors.
module ps2_letter_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [4:0] char,
    output logic       char_valid,
    output logic       enter_valid,
    output logic       frame_err
);
    localparam int            WW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    F_LIM  = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          pclk_s1_q, pclk_s2_q, pdat_s1_q, pdat_s2_q;
    logic          filt_q;
    logic [3:0]    fcnt_q;
    logic          fall;
    logic          timeout;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          rdy_q, rdy_d, err_q, err_d;
    logic [7:0]    held_q, held_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic [4:0]    char_q, char_d;
    logic [4:0]    letter;
    logic          char_stb, enter_stb;

    function automatic logic [4:0] map_letter(input logic [7:0] code);
        case (code)
            8'h1C: return 5'd1;   8'h32: return 5'd2;   8'h21: return 5'd3;
            8'h23: return 5'd4;   8'h24: return 5'd5;   8'h2B: return 5'd6;
            8'h34: return 5'd7;   8'h33: return 5'd8;   8'h43: return 5'd9;
            8'h3B: return 5'd10;  8'h42: return 5'd11;  8'h4B: return 5'd12;
            8'h3A: return 5'd13;  8'h31: return 5'd14;  8'h44: return 5'd15;
            8'h4D: return 5'd16;  8'h15: return 5'd17;  8'h2D: return 5'd18;
            8'h1B: return 5'd19;  8'h2C: return 5'd20;  8'h3C: return 5'd21;
            8'h2A: return 5'd22;  8'h1D: return 5'd23;  8'h22: return 5'd24;
            8'h35: return 5'd25;  8'h1A: return 5'd26;
            default: return 5'd0;
        endcase
    endfunction

    // The filtered clock flips on the cycle the FILTER_LEN-th differing sample arrives.
    assign fall    = filt_q && !pclk_s2_q && (fcnt_q == F_LIM);
    assign timeout = (wd_q == WD_LIM);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        wd_d      = wd_q + WW'(1);
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        if (state_q == S_IDLE || fall) begin
            wd_d = '0;
        end
        case (state_q)
            S_IDLE: begin
                if (fall && !pdat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {pdat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = pdat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if ((^{shift_q, par_q}) && pdat_s2_q) begin
                        rdy_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !fall && timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    // shift_q still holds the received byte during the rdy_q cycle.
    assign letter = map_letter(shift_q);

    always_comb begin
        held_d    = held_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        char_d    = char_q;
        char_stb  = 1'b0;
        enter_stb = 1'b0;
        if (err_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rdy_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                if (!ext_q && shift_q == held_q) begin
                    held_d = 8'h00;
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (ext_q) begin
                ext_d = 1'b0;
            end else if (shift_q != held_q) begin
                held_d = shift_q;
                if (letter != 5'd0) begin
                    char_d   = letter;
                    char_stb = 1'b1;
                end else if (shift_q == 8'h5A) begin
                    enter_stb = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pclk_s1_q <= 1'b1;
            pclk_s2_q <= 1'b1;
            pdat_s1_q <= 1'b1;
            pdat_s2_q <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= 4'd0;
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            wd_q      <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            held_q    <= 8'h00;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            char_q    <= 5'd0;
        end else begin
            pclk_s1_q <= ps2_clk;
            pclk_s2_q <= pclk_s1_q;
            pdat_s1_q <= ps2_dat;
            pdat_s2_q <= pdat_s1_q;
            if (pclk_s2_q == filt_q) begin
                fcnt_q <= 4'd0;
            end else if (fcnt_q == F_LIM) begin
                filt_q <= pclk_s2_q;
                fcnt_q <= 4'd0;
            end else begin
                fcnt_q <= fcnt_q + 4'd1;
            end
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            wd_q      <= wd_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            held_q    <= held_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            char_q    <= char_d;
        end
    end

    assign char        = char_stb ? letter : char_q;
    assign char_valid  = char_stb;
    assign enter_valid = enter_stb;
    assign frame_err   = err_q;

endmodule

// File: doc/ps2_letter_rx.md
Name: ps2_letter_rx

Overview:
- PS/2 keyboard receiver; the producer end of the `char`/`guess` interface consumed by the game datapath.
- Deserialises scan-code-set-2 frames from the keyboard and tracks break (F0) and extended (E0) prefixes.
- Suppresses typematic repeats and emits one-cycle strobes: a 5-bit letter code (A=1 … Z=26), Enter, and frame errors.
- Sits between the board PS/2 pins and the control/datapath pair.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples needed before the filtered ps2_clk level changes (range 2..15).
- TIMEOUT_CYCLES, 50000: clk cycles with no filtered falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous active-low reset.
- ps2_clk  in  1  raw keyboard clock, asynchronous.
- ps2_dat  in  1  raw keyboard data, asynchronous.
- char  out  5  letter code 1..26; holds the last emitted letter.
- char_valid  out  1  one-cycle strobe: new letter press on `char`.
- enter_valid  out  1  one-cycle strobe: Enter (make code 5A) pressed.
- frame_err  out  1  one-cycle strobe: parity, stop or timeout error.

Behaviour:
- Reset: one clock, synchronous, active-low, sampled on the clk rising edge (resetn=0). Clears all state; outputs char=0, char_valid=0, enter_valid=0, frame_err=0.
- Synchronisation and filtering:
  - ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
  - Filtered clock resets to 1; it takes the synchronised level only after FILTER_LEN equal consecutive samples.
  - fall = filtered transition 1→0, asserted for one cycle. All bit sampling uses the synchronised ps2_dat on fall cycles only.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall, if data=0 → DATA with bit_cnt=0; if data=1, stay in IDLE with no error.
  - DATA: on fall, shift data into shift[7:0] LSB first; after the 8th bit → PARITY.
  - PARITY: on fall, capture the parity bit → STOP.
  - STOP: on fall, the frame is good iff ^{shift,parity}==1 (odd parity) and data=1. Either way → IDLE.
  - Watchdog counter clears on every fall and while in IDLE. Reaching TIMEOUT_CYCLES-1 in DATA, PARITY or STOP → IDLE, frame_err=1 for one cycle, prefix flags cleared.
  - Bad parity or stop=0: frame_err pulse, byte discarded, brk and ext flags cleared.
- Byte decode runs in the cycle after a good STOP fall, so strobes appear 1 clk after the stop-bit fall cycle.
  - E0: set ext, no output.
  - F0: set brk, no output.
  - Any other code with brk=1 (release):
    - if ext=0 and code==held, clear held to 00;
    - in all cases clear brk and ext; no output.
  - Any other code with ext=1, brk=0: clear ext; no output (extended keys ignored).
  - Otherwise (make):
    - if code==held, it is a typematic repeat: no output;
    - else set held=code, and on a letter set char=map(code) and pulse char_valid, or on 5A pulse enter_valid;
    - other codes update held only.
- Letter map: 1C=1, 32=2, 21=3, 23=4, 24=5, 2B=6, 34=7, 33=8, 43=9, 3B=10, 42=11, 4B=12, 3A=13, 31=14, 44=15, 4D=16, 15=17, 2D=18, 1B=19, 2C=20, 3C=21, 2A=22, 1D=23, 22=24, 35=25, 1A=26.
- Strobe timing:
  - char_valid, enter_valid and frame_err are never high for more than one cycle.
  - At most one of them is high in any cycle.
  - char changes only in the cycle char_valid is high.
- held is 8 bits, reset value 00. A new different make replaces held, so rollover (pressing a second key while the first is held) emits the second key.
- Reset mid-frame: FSM to IDLE, partial frame discarded, no frame_err; the next start bit begins a clean frame.

Test Plan:
- Frame 0x1C with correct parity (1→0 LSB-first bits 0,0,1,1,1,0,0,0; parity 0; stop 1), keyboard clock 12.5 kHz → char=1, char_valid high exactly 1 cycle, 1 clk after the stop-bit fall.
- Sequence 2D, 2D, 2D, F0, 2D, 2D → exactly two char_valid pulses, both with char=18; no pulse on the repeats or the release.
- Frame 0x5A with parity forced wrong → frame_err one pulse, no enter_valid. The next correct 5A gives enter_valid one pulse.
- Sequence E0, 75, E0, F0, 75, then 1A → no strobes until char=26 with a char_valid pulse.
- 4 data bits sent, then ps2_clk held high for 60000 cycles → frame_err pulse at cycle TIMEOUT_CYCLES after the last fall. A following 0x43 frame gives char=9.
- resetn=0 for one cycle during a 0x15 frame after its 5th data bit → all outputs 0 and no frame_err. Remaining bits are rejected without a strobe: a 1 returns to IDLE silently; any 0 starts a frame that aborts by parity/stop or times out with frame_err. After the timeout, a fresh 0x15 frame gives char=17.
- Glitch check: a 2-cycle low glitch on ps2_clk with FILTER_LEN=4 produces no fall and no bit shift.
